// File: rtl/dsp_mem_loader_if.sv
// Host byte stream in, shared memory write port out.
// Carries status flags back to the host side.
interface dsp_mem_loader_if #(
  parameter int DATA_WIDTH = 36,
  parameter int ADDR_WIDTH = 10
);
  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  instr_wr_en;
  logic                  coeff_wr_en;
  logic                  sample_wr_en;
  logic                  busy;
  logic                  done;
  logic                  cksum_err;
  logic                  frame_err;

  modport master (
    output rx_data, rx_valid,
    input  rx_ready, wr_addr, wr_data,
    input  instr_wr_en, coeff_wr_en, sample_wr_en,
    input  busy, done, cksum_err, frame_err
  );

  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, wr_addr, wr_data,
    output instr_wr_en, coeff_wr_en, sample_wr_en,
    output busy, done, cksum_err, frame_err
  );
endinterface

// File: rtl/dsp_mem_loader.sv
// Framed byte-stream loader for the DSP instr/coeff/sample memories.
// Emits 1-cycle write strobes on a shared addr/data bus.
module dsp_mem_loader #(
  parameter int          DATA_WIDTH = 36,
  parameter int          ADDR_WIDTH = 10,
  parameter int          WORD_BYTES = 5,
  parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
  input logic            clk,
  input logic            reset,
  dsp_mem_loader_if.slave bus
);

  localparam int BW = (WORD_BYTES > 1) ?
                      $clog2(WORD_BYTES) : 1;
  localparam logic [BW-1:0] LAST_BYTE =
    BW'(WORD_BYTES - 1);
  localparam int HW = ADDR_WIDTH - 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TARGET,
    S_ADDR_HI,
    S_ADDR_LO,
    S_CNT_HI,
    S_CNT_LO,
    S_DATA,
    S_CKSUM
  } state_e;

  state_e                state_q, state_d;
  logic                  rdy_q;
  logic [7:0]            acc_q, acc_d;
  logic [1:0]            tgt_q, tgt_d;
  logic [HW-1:0]         ahi_q, ahi_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            chi_q, chi_d;
  logic [15:0]           cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [BW-1:0]         bidx_q, bidx_d;
  logic [ADDR_WIDTH-1:0] wra_q, wra_d;
  logic [DATA_WIDTH-1:0] wrd_q, wrd_d;
  logic [2:0]            wen_q, wen_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  cerr_q, cerr_d;
  logic                  ferr_q, ferr_d;

  logic                  accept;
  logic                  is_sync;
  logic                  bad_tgt;
  logic                  word_end;
  logic [15:0]           cnt_in;
  logic [7:0]            sum_in;
  logic [DATA_WIDTH-1:0] shift_in;

  assign accept   = bus.rx_valid & rdy_q;
  assign is_sync  = (bus.rx_data == SYNC_BYTE);
  assign bad_tgt  = (bus.rx_data > 8'd2);
  assign word_end = (bidx_q == LAST_BYTE);
  assign cnt_in   = {chi_q, bus.rx_data};
  assign sum_in   = acc_q + bus.rx_data;
  // Bytes arrive MSB first; bits above the word fall off the top.
  assign shift_in = (shift_q << 8) |
                    DATA_WIDTH'(bus.rx_data);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next state: moves only on an accepted byte
  always_comb begin
    state_d = state_q;
    if (accept) begin
      unique case (state_q)
        S_IDLE:
          if (is_sync) state_d = S_TARGET;
        S_TARGET:
          state_d = bad_tgt ? S_IDLE : S_ADDR_HI;
        S_ADDR_HI: state_d = S_ADDR_LO;
        S_ADDR_LO: state_d = S_CNT_HI;
        S_CNT_HI:  state_d = S_CNT_LO;
        S_CNT_LO:
          state_d = (cnt_in == 16'd0) ?
                    S_CKSUM : S_DATA;
        S_DATA:
          if (word_end && cnt_q == 16'd1)
            state_d = S_CKSUM;
        S_CKSUM:   state_d = S_IDLE;
        default:   state_d = S_IDLE;
      endcase
    end
  end

  // Outputs and datapath next values per state
  always_comb begin
    acc_d   = acc_q;
    tgt_d   = tgt_q;
    ahi_d   = ahi_q;
    addr_d  = addr_q;
    chi_d   = chi_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    bidx_d  = bidx_q;
    wra_d   = wra_q;
    wrd_d   = wrd_q;
    wen_d   = 3'b000;
    busy_d  = busy_q;
    done_d  = 1'b0;
    cerr_d  = cerr_q;
    ferr_d  = 1'b0;
    if (accept) begin
      acc_d = sum_in;
      unique case (state_q)
        S_IDLE: begin
          acc_d = acc_q;
          if (is_sync) begin
            busy_d = 1'b1;
            cerr_d = 1'b0;
            acc_d  = 8'd0;
          end
        end
        S_TARGET: begin
          if (bad_tgt) begin
            ferr_d = 1'b1;
            busy_d = 1'b0;
          end else begin
            tgt_d = bus.rx_data[1:0];
          end
        end
        S_ADDR_HI: ahi_d = bus.rx_data[HW-1:0];
        S_ADDR_LO: addr_d = {ahi_q, bus.rx_data};
        S_CNT_HI:  chi_d = bus.rx_data;
        S_CNT_LO: begin
          cnt_d  = cnt_in;
          bidx_d = '0;
        end
        S_DATA: begin
          shift_d = shift_in;
          if (word_end) begin
            bidx_d = '0;
            wrd_d  = shift_in;
            wra_d  = addr_q;
            addr_d = addr_q + ADDR_WIDTH'(1);
            cnt_d  = cnt_q - 16'd1;
            unique case (1'b1)
              (tgt_q == 2'd0): wen_d = 3'b001;
              (tgt_q == 2'd1): wen_d = 3'b010;
              (tgt_q == 2'd2): wen_d = 3'b100;
              default:         wen_d = 3'b000;
            endcase
          end else begin
            bidx_d = bidx_q + BW'(1);
          end
        end
        S_CKSUM: begin
          done_d = 1'b1;
          busy_d = 1'b0;
          cerr_d = (sum_in != 8'd0);
        end
        default: ;
      endcase
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdy_q   <= 1'b0;
      acc_q   <= '0;
      tgt_q   <= '0;
      ahi_q   <= '0;
      addr_q  <= '0;
      chi_q   <= '0;
      cnt_q   <= '0;
      shift_q <= '0;
      bidx_q  <= '0;
      wra_q   <= '0;
      wrd_q   <= '0;
      wen_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cerr_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      rdy_q   <= 1'b1;
      acc_q   <= acc_d;
      tgt_q   <= tgt_d;
      ahi_q   <= ahi_d;
      addr_q  <= addr_d;
      chi_q   <= chi_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      bidx_q  <= bidx_d;
      wra_q   <= wra_d;
      wrd_q   <= wrd_d;
      wen_q   <= wen_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cerr_q  <= cerr_d;
      ferr_q  <= ferr_d;
    end
  end

  assign bus.rx_ready     = rdy_q;
  assign bus.wr_addr      = wra_q;
  assign bus.wr_data      = wrd_q;
  assign bus.instr_wr_en  = wen_q[0];
  assign bus.coeff_wr_en  = wen_q[1];
  assign bus.sample_wr_en = wen_q[2];
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.cksum_err    = cerr_q;
  assign bus.frame_err    = ferr_q;

endmodule

// File: tb/tb_dsp_mem_loader.sv
// Random/directed frames against a frame-level model.
// Writes are collected and compared per frame.
module tb_dsp_mem_loader;

  typedef struct packed {
    logic [1:0]  tgt;
    logic [9:0]  addr;
    logic [35:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic reset = 1'b1;

  dsp_mem_loader_if #(
    .DATA_WIDTH(36), .ADDR_WIDTH(10)
  ) bus ();

  dsp_mem_loader #(
    .DATA_WIDTH(36), .ADDR_WIDTH(10),
    .WORD_BYTES(5), .SYNC_BYTE(8'hA5)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int done_cnt = 0;
  int ferr_cnt = 0;
  int multi_cnt = 0;
  wr_t got_q[$];
  wr_t exp_q[$];
  logic [39:0] words_q[$];

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h",
                  tag, obs, exp);
  endtask

  // Collect write strobes and status pulses
  always @(negedge clk) begin : mon
    int n;
    n = 0;
    if (!reset) begin
      n = int'(bus.instr_wr_en) +
          int'(bus.coeff_wr_en) +
          int'(bus.sample_wr_en);
      if (n > 1) multi_cnt++;
      if (n != 0)
        got_q.push_back({
          bus.sample_wr_en ? 2'd2 :
          bus.coeff_wr_en  ? 2'd1 : 2'd0,
          bus.wr_addr, bus.wr_data});
      if (bus.done) done_cnt++;
      if (bus.frame_err) ferr_cnt++;
    end
  end

  task automatic send(input logic [7:0] b,
                      input int maxgap);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    repeat ($urandom_range(maxgap, 0))
      @(negedge clk);
  endtask

  task automatic clear_mon();
    got_q.delete();
    exp_q.delete();
    done_cnt = 0;
    ferr_cnt = 0;
  endtask

  task automatic run_frame(input string tag,
                           input logic [7:0] tgt,
                           input logic [15:0] addr,
                           input logic [7:0] ck_off,
                           input int maxgap);
    logic [7:0]  sum;
    logic [7:0]  ck;
    logic [7:0]  b;
    logic [15:0] c16;
    logic [7:0]  hdr [5];
    clear_mon();
    c16 = 16'(words_q.size());
    hdr = '{tgt, addr[15:8], addr[7:0],
            c16[15:8], c16[7:0]};
    sum = 8'd0;
    send(8'hA5, maxgap);
    for (int i = 0; i < 5; i++) begin
      send(hdr[i], maxgap);
      sum = sum + hdr[i];
    end
    for (int i = 0; i < words_q.size(); i++) begin
      for (int k = 4; k >= 0; k--) begin
        b = words_q[i][8*k +: 8];
        send(b, maxgap);
        sum = sum + b;
      end
      exp_q.push_back({tgt[1:0],
        10'((int'(addr) + i) % 1024),
        words_q[i][35:0]});
    end
    ck = 8'(8'd0 - sum) + ck_off;
    send(ck, maxgap);
    repeat (4) @(negedge clk);
    chk({tag, " nwr"}, 64'(got_q.size()),
        64'(exp_q.size()));
    for (int i = 0; i < got_q.size() &&
         i < exp_q.size(); i++)
      chk({tag, " wr"}, 64'(got_q[i]),
          64'(exp_q[i]));
    chk({tag, " done"}, 64'(done_cnt), 64'd1);
    chk({tag, " cksum_err"}, 64'(bus.cksum_err),
        64'(ck_off != 8'd0));
    chk({tag, " busy"}, 64'(bus.busy), 64'd0);
    chk({tag, " ferr"}, 64'(ferr_cnt), 64'd0);
  endtask

  task automatic rand_words(input int n);
    words_q.delete();
    for (int i = 0; i < n; i++)
      words_q.push_back({8'($urandom), 32'($urandom)});
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " wen"}, 64'({bus.instr_wr_en,
        bus.coeff_wr_en, bus.sample_wr_en}), 64'd0);
    chk({tag, " busy"}, 64'(bus.busy), 64'd0);
    chk({tag, " done"}, 64'(bus.done), 64'd0);
    chk({tag, " cerr"}, 64'(bus.cksum_err), 64'd0);
    chk({tag, " ferr"}, 64'(bus.frame_err), 64'd0);
    chk({tag, " addr"}, 64'(bus.wr_addr), 64'd0);
    chk({tag, " data"}, 64'(bus.wr_data), 64'd0);
    chk({tag, " rdy"}, 64'(bus.rx_ready), 64'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit hit");
    $fatal(1);
  end

  initial begin
    logic [7:0] off;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    repeat (2) @(negedge clk);
    chk_zero("rst");
    reset = 1'b0;
    @(negedge clk);
    chk("rdy after rst", 64'(bus.rx_ready), 64'd1);

    words_q = '{40'h00_00000001, 40'h0F_FFFFFFFF};
    run_frame("t1", 8'd0, 16'h0010, 8'd0, 0);
    run_frame("t1gap", 8'd0, 16'h0010, 8'd0, 5);

    rand_words(3);
    run_frame("t2", 8'd1, 16'h03FF, 8'd0, 2);

    words_q.delete();
    run_frame("t3", 8'd1, 16'h0000, 8'd0, 1);

    words_q = '{40'h00_00000001, 40'h0F_FFFFFFFF};
    run_frame("t4", 8'd0, 16'h0010, 8'd1, 1);
    clear_mon();
    send(8'hA5, 0);
    repeat (2) @(negedge clk);
    chk("t4 sync cerr", 64'(bus.cksum_err), 64'd0);
    chk("t4 sync busy", 64'(bus.busy), 64'd1);
    send(8'h03, 0);
    repeat (2) @(negedge clk);
    chk("t4 abort ferr", 64'(ferr_cnt), 64'd1);
    chk("t4 abort busy", 64'(bus.busy), 64'd0);

    clear_mon();
    send(8'h00, 1);
    send(8'hFF, 1);
    send(8'h12, 1);
    send(8'hA5, 1);
    send(8'h03, 1);
    repeat (3) @(negedge clk);
    chk("t5 nwr", 64'(got_q.size()), 64'd0);
    chk("t5 ferr", 64'(ferr_cnt), 64'd1);
    chk("t5 busy", 64'(bus.busy), 64'd0);
    chk("t5 done", 64'(done_cnt), 64'd0);
    rand_words(2);
    run_frame("t5ok", 8'd2, 16'h0123, 8'd0, 3);

    clear_mon();
    send(8'hA5, 0);
    send(8'h00, 0);
    send(8'h00, 0);
    send(8'h20, 0);
    send(8'h00, 0);
    send(8'h01, 0);
    send(8'h11, 0);
    send(8'h22, 0);
    send(8'h33, 0);
    chk("t6 busy mid", 64'(bus.busy), 64'd1);
    reset = 1'b1;
    #1;
    chk_zero("t6 rst");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("t6 nwr", 64'(got_q.size()), 64'd0);
    chk("t6 done", 64'(done_cnt), 64'd0);
    rand_words(2);
    run_frame("t6ok", 8'd0, 16'h0020, 8'd0, 2);

    for (int f = 0; f < 8; f++) begin
      rand_words($urandom_range(6, 0));
      off = ($urandom_range(3, 0) == 0) ?
            8'($urandom_range(255, 1)) : 8'd0;
      run_frame("rnd", 8'($urandom_range(2, 0)),
                16'($urandom), off, 5);
    end

    chk("one-hot wen", 64'(multi_cnt), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
